// File: rtl/present_pkg.sv
// Shared PRESENT constants: state geometry, inverse S-box table and
// the FSM state type used by the serialised substitution layers.
package present_pkg;

    localparam int STATE_W = 64;
    localparam int NIB_W   = 4;

    // Indexed by the input nibble; entry i is the inverse S-box output for i.
    localparam logic [NIB_W-1:0] INV_SBOX [16] = '{
        4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
        4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_t;

endpackage

// File: rtl/present_inv_sbox.sv
// Single 4-bit PRESENT inverse S-box, purely combinational.
module present_inv_sbox
    import present_pkg::*;
(
    input  logic [NIB_W-1:0] din,
    output logic [NIB_W-1:0] dout
);

    always_comb begin
        dout = INV_SBOX[din];
    end

endmodule

// File: rtl/present_inv_sbox_layer.sv
// Serialised PRESENT inverse substitution layer: NPC nibbles per cycle
// through a right-rotating 64-bit state register, valid/ready on both sides.
module present_inv_sbox_layer
    import present_pkg::*;
#(
    parameter int NPC = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_state,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_state,
    input  logic               scand,
    output logic               scanq
);

    localparam int NGRP  = 16 / NPC;
    localparam int GRP_W = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam int SUB_W = NIB_W * NPC;
    localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(NGRP - 1);

    generate
        if (!(NPC == 1 || NPC == 2 || NPC == 4 || NPC == 8 || NPC == 16)) begin : g_bad_npc
            $error("present_inv_sbox_layer: NPC must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    fsm_t               fsm_reg, fsm_next;
    logic [STATE_W-1:0] state_reg, state_next;
    logic [GRP_W-1:0]   grp_reg, grp_next;
    logic               in_ready_reg, out_valid_reg;
    logic               scanq_reg;
    logic [SUB_W-1:0]   sub_group;
    logic [STATE_W-1:0] rotated;

    generate
        for (genvar gi = 0; gi < NPC; gi++) begin : g_sbox
            present_inv_sbox u_sbox (
                .din  (state_reg[NIB_W*gi +: NIB_W]),
                .dout (sub_group[NIB_W*gi +: NIB_W])
            );
        end

        // Substituted group re-enters at the top so NGRP rotations restore nibble order.
        if (NPC == 16) begin : g_rot_full
            assign rotated = sub_group;
        end else begin : g_rot_part
            assign rotated = {sub_group, state_reg[STATE_W-1:SUB_W]};
        end
    endgenerate

    always_comb begin
        fsm_next   = fsm_reg;
        state_next = state_reg;
        grp_next   = grp_reg;
        case (fsm_reg)
            IDLE: begin
                if (in_valid) begin
                    state_next = in_state;
                    grp_next   = '0;
                    fsm_next   = BUSY;
                end
            end
            BUSY: begin
                state_next = rotated;
                grp_next   = grp_reg + 1'b1;
                if (grp_reg == GRP_LAST) begin
                    fsm_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    fsm_next = IDLE;
                end
            end
            default: fsm_next = IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so they track fsm_reg exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_reg       <= IDLE;
            state_reg     <= '0;
            grp_reg       <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            fsm_reg       <= fsm_next;
            state_reg     <= state_next;
            grp_reg       <= grp_next;
            in_ready_reg  <= (fsm_next == IDLE);
            out_valid_reg <= (fsm_next == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scanq_reg <= 1'b0;
        end else begin
            scanq_reg <= scand;
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_state = state_reg;
    assign scanq     = scanq_reg;

endmodule
